// File: rtl/vst_pattern_gen.sv
// Video test-pattern source: emits an optional control packet followed by a
// video packet per frame on a valid/ready stream (ready latency 0).
// Optional control packet enabled by macro VST_PATTERN_GEN_CTRL_PKT_EN.
module vst_pattern_gen #(
  parameter int unsigned           DATA_WIDTH    = 10,
  parameter int unsigned           IM_WIDTH      = 720,
  parameter int unsigned           IM_HEIGHT     = 576,
  parameter logic [3:0]            IM_INTERLACED = 4'd0,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE    = DATA_WIDTH'(512)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket,
  output logic                  frame_done
);

  localparam int unsigned   CW       = 16;
  localparam int unsigned   BAR_LEN  = IM_WIDTH / 8;
  localparam logic [CW-1:0] X_LAST   = CW'(IM_WIDTH - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(IM_HEIGHT - 1);
  localparam logic [CW-1:0] BAR_LAST = CW'(BAR_LEN - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_VID_HDR   = 3'd3;
  localparam logic [2:0] S_VID_DATA  = 3'd4;
`ifdef VST_PATTERN_GEN_CTRL_PKT_EN
  localparam logic [2:0] S_CTRL_HDR  = 3'd1;
  localparam logic [2:0] S_CTRL_BODY = 3'd2;
  localparam logic [15:0] W16 = 16'(IM_WIDTH);
  localparam logic [15:0] H16 = 16'(IM_HEIGHT);

  // Control-packet body nibble for beat index 0..8
  function automatic logic [3:0] ctrl_nib(input logic [3:0] idx);
    case (idx)
      4'd0:    ctrl_nib = W16[15:12];
      4'd1:    ctrl_nib = W16[11:8];
      4'd2:    ctrl_nib = W16[7:4];
      4'd3:    ctrl_nib = W16[3:0];
      4'd4:    ctrl_nib = H16[15:12];
      4'd5:    ctrl_nib = H16[11:8];
      4'd6:    ctrl_nib = H16[7:4];
      4'd7:    ctrl_nib = H16[3:0];
      4'd8:    ctrl_nib = IM_INTERLACED;
      default: ctrl_nib = 4'd0;
    endcase
  endfunction

  logic [3:0] beat_q, beat_d;
`endif

  // Pixel value for the latched pattern at (px, py) in bar b
  function automatic logic [DATA_WIDTH-1:0] pix(input logic [1:0] sel,
                                                input logic [CW-1:0] px,
                                                input logic [CW-1:0] py,
                                                input logic [2:0] b);
    case (sel)
      2'd0:    pix = FILL_VALUE;
      2'd1:    pix = DATA_WIDTH'(px);
      2'd2:    pix = DATA_WIDTH'({b, {(DATA_WIDTH-3){1'b0}}});
      default: pix = (px[4] ^ py[4]) ? '1 : '0;
    endcase
  endfunction

  logic [2:0]            state_q, state_d;
  logic [1:0]            pat_q, pat_d;
  logic [CW-1:0]         x_q, x_d, y_q, y_d, bcnt_q, bcnt_d;
  logic [2:0]            bar_q, bar_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic                  fd_q, fd_d;

  logic [CW-1:0] nx, ny, nbcnt;
  logic [2:0]    nbar;
  logic          line_end, bar_end, frame_last, n_last;

  // Raster position of the pixel that follows the one on the output
  always_comb begin
    line_end   = (x_q == X_LAST);
    bar_end    = (bcnt_q == BAR_LAST);
    frame_last = line_end && (y_q == Y_LAST);
    nx         = line_end ? '0 : CW'(x_q + 16'd1);
    ny         = line_end ? CW'(y_q + 16'd1) : y_q;
    nbcnt      = (line_end || bar_end) ? '0 : CW'(bcnt_q + 16'd1);
    nbar       = line_end ? 3'd0 : (bar_end ? 3'(bar_q + 3'd1) : bar_q);
    n_last     = (nx == X_LAST) && (ny == Y_LAST);
  end

  // Next-state and output-register logic; a beat advances only on transfer
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    x_d     = x_q;
    y_d     = y_q;
    bcnt_d  = bcnt_q;
    bar_d   = bar_q;
    data_d  = data_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    fd_d    = 1'b0;
`ifdef VST_PATTERN_GEN_CTRL_PKT_EN
    beat_d  = beat_q;
`endif
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        data_d  = '0;
        if (enable) begin
          pat_d   = pattern_sel;
          valid_d = 1'b1;
          sop_d   = 1'b1;
`ifdef VST_PATTERN_GEN_CTRL_PKT_EN
          state_d = S_CTRL_HDR;
          data_d  = DATA_WIDTH'(4'hF);
`else
          state_d = S_VID_HDR;
`endif
        end
      end
`ifdef VST_PATTERN_GEN_CTRL_PKT_EN
      S_CTRL_HDR: begin
        if (dout_ready) begin
          state_d = S_CTRL_BODY;
          beat_d  = 4'd0;
          data_d  = DATA_WIDTH'(ctrl_nib(4'd0));
          sop_d   = 1'b0;
          eop_d   = 1'b0;
        end
      end
      S_CTRL_BODY: begin
        if (dout_ready) begin
          if (beat_q == 4'd8) begin
            state_d = S_VID_HDR;
            data_d  = '0;
            sop_d   = 1'b1;
            eop_d   = 1'b0;
          end else begin
            beat_d  = 4'(beat_q + 4'd1);
            data_d  = DATA_WIDTH'(ctrl_nib(4'(beat_q + 4'd1)));
            eop_d   = (beat_q == 4'd7);
          end
        end
      end
`endif
      S_VID_HDR: begin
        if (dout_ready) begin
          state_d = S_VID_DATA;
          x_d     = '0;
          y_d     = '0;
          bcnt_d  = '0;
          bar_d   = 3'd0;
          data_d  = pix(pat_q, '0, '0, 3'd0);
          sop_d   = 1'b0;
          eop_d   = 1'b0;
        end
      end
      S_VID_DATA: begin
        if (dout_ready) begin
          if (frame_last) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            eop_d   = 1'b0;
            data_d  = '0;
            fd_d    = 1'b1;
            x_d     = '0;
            y_d     = '0;
            bcnt_d  = '0;
            bar_d   = 3'd0;
          end else begin
            x_d     = nx;
            y_d     = ny;
            bcnt_d  = nbcnt;
            bar_d   = nbar;
            data_d  = pix(pat_q, nx, ny, nbar);
            eop_d   = n_last;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        data_d  = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pat_q   <= 2'd0;
      x_q     <= '0;
      y_q     <= '0;
      bcnt_q  <= '0;
      bar_q   <= 3'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      fd_q    <= 1'b0;
`ifdef VST_PATTERN_GEN_CTRL_PKT_EN
      beat_q  <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      x_q     <= x_d;
      y_q     <= y_d;
      bcnt_q  <= bcnt_d;
      bar_q   <= bar_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      fd_q    <= fd_d;
`ifdef VST_PATTERN_GEN_CTRL_PKT_EN
      beat_q  <= beat_d;
`endif
    end
  end

  assign dout_data          = data_q;
  assign dout_valid         = valid_q;
  assign dout_startofpacket = sop_q;
  assign dout_endofpacket   = eop_q;
  assign frame_done         = fd_q;

endmodule

// File: tb/tb_vst_pattern_gen.sv
// Bench for vst_pattern_gen (16x18 frame, 10-bit symbols); follows
// VST_PATTERN_GEN_CTRL_PKT_EN to decide whether a control packet is expected.
module tb_vst_pattern_gen;

  localparam int DW = 10;
  localparam int W  = 16;
  localparam int H  = 18;
`ifdef VST_PATTERN_GEN_CTRL_PKT_EN
  localparam int HDR = 11;
`else
  localparam int HDR = 1;
`endif
  localparam int FLEN = HDR + W * H;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
    logic          last;
  } beat_t;

  logic          clk, rst_n, enable, dout_ready;
  logic [1:0]    pattern_sel;
  logic [DW-1:0] dout_data;
  logic          dout_valid, dout_startofpacket, dout_endofpacket, frame_done;

  vst_pattern_gen #(.DATA_WIDTH(DW), .IM_WIDTH(W), .IM_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_startofpacket(dout_startofpacket), .dout_endofpacket(dout_endofpacket),
    .frame_done(frame_done)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    total_xfers = 0;
  int    rdy_mode = 0;
  beat_t exp_q[$];
  beat_t mon_e;
  logic          prev_stall = 1'b0;
  logic          fd_exp = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_sop, prev_eop;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference pixel from the pattern definitions
  function automatic logic [DW-1:0] exp_pix(input int pat, input int x, input int y);
    case (pat)
      0:       return DW'(512);
      1:       return DW'(x % (1 << DW));
      2:       return DW'((x / (W / 8)) * (1 << (DW - 3)));
      default: return (((x / 16) % 2) != ((y / 16) % 2)) ? DW'(1023) : DW'(0);
    endcase
  endfunction

  // Append one whole frame of expected beats to the scoreboard
  task automatic push_frame(input int pat);
    int nib;
`ifdef VST_PATTERN_GEN_CTRL_PKT_EN
    exp_q.push_back('{d: DW'(15), sop: 1'b1, eop: 1'b0, last: 1'b0});
    for (int i = 0; i < 9; i++) begin
      if (i < 4)      nib = (W >> (12 - 4 * i)) & 15;
      else if (i < 8) nib = (H >> (12 - 4 * (i - 4))) & 15;
      else            nib = 0;
      exp_q.push_back('{d: DW'(nib), sop: 1'b0, eop: (i == 8), last: 1'b0});
    end
`endif
    exp_q.push_back('{d: DW'(0), sop: 1'b1, eop: 1'b0, last: 1'b0});
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back('{d: exp_pix(pat, x, y), sop: 1'b0,
                          eop: (x == W - 1 && y == H - 1), last: (x == W - 1 && y == H - 1)});
  endtask

  // Ready driver: always-ready or random 50% duty
  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      dout_ready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Per-cycle compare against the scoreboard, stall stability and frame_done
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      fd_exp     = 1'b0;
    end else begin
      chk("frame_done", 32'(frame_done), 32'(fd_exp));
      if (fd_exp) chk("gap_valid", 32'(dout_valid), 32'd0);
      fd_exp = 1'b0;
      if (prev_stall) begin
        chk("hold_valid", 32'(dout_valid), 32'd1);
        chk("hold_data", 32'(dout_data), 32'(prev_data));
        chk("hold_sop", 32'(dout_startofpacket), 32'(prev_sop));
        chk("hold_eop", 32'(dout_endofpacket), 32'(prev_eop));
      end
      if (dout_valid && dout_ready) begin
        total_xfers++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got data 0x%0h expected no beat at %0t", dout_data, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_data", 32'(dout_data), 32'(mon_e.d));
          chk("beat_sop", 32'(dout_startofpacket), 32'(mon_e.sop));
          chk("beat_eop", 32'(dout_endofpacket), 32'(mon_e.eop));
          fd_exp = mon_e.last;
        end
      end
      prev_stall = dout_valid && !dout_ready;
      prev_data  = dout_data;
      prev_sop   = dout_startofpacket;
      prev_eop   = dout_endofpacket;
    end
  end

  task automatic wait_drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  // Start a frame, drop enable once it is running, and let it complete
  task automatic start_frames(input int pat, input int nframes);
    int start;
    int cyc = 0;
    for (int i = 0; i < nframes; i++) push_frame(pat);
    pattern_sel = 2'(pat);
    start = total_xfers;
    @(posedge clk);
    #1 enable = 1'b1;
    while (total_xfers < start + (nframes - 1) * FLEN + 1 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    enable = 1'b0;
    pattern_sel = ~2'(pat);
    wait_drain();
  endtask

  initial begin
    int start;
    int cyc;
    rst_n = 1'b0;
    enable = 1'b0;
    pattern_sel = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_sop", 32'(dout_startofpacket), 32'd0);
    chk("rst_eop", 32'(dout_endofpacket), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_data", 32'(dout_data), 32'd0);

    // Pin the model against hand-computed values
    push_frame(2);
    chk("model_len", 32'(exp_q.size()), 32'(FLEN));
`ifdef VST_PATTERN_GEN_CTRL_PKT_EN
    chk("model_ctrl_hdr", 32'(exp_q[0].d), 32'hF);
    chk("model_w_lo", 32'(exp_q[3].d), 32'd1);
    chk("model_h_mid", 32'(exp_q[7].d), 32'd1);
    chk("model_h_lo", 32'(exp_q[8].d), 32'd2);
    chk("model_ctrl_eop", 32'(exp_q[9].eop), 32'd1);
`endif
    chk("model_vid_sop", 32'(exp_q[HDR-1].sop), 32'd1);
    chk("model_bar1", 32'(exp_q[HDR+3].d), 32'd128);
    chk("model_bar7", 32'(exp_q[HDR+15].d), 32'd896);
    chk("model_last_eop", 32'(exp_q[FLEN-1].eop), 32'd1);
    exp_q.delete();
    chk("model_ramp", 32'(exp_pix(1, 13, 4)), 32'd13);
    chk("model_chk_on", 32'(exp_pix(3, 3, 16)), 32'h3FF);
    chk("model_chk_off", 32'(exp_pix(3, 3, 2)), 32'd0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_valid", 32'(dout_valid), 32'd0);

    // Full-throughput frames, every pattern
    for (int p = 0; p < 4; p++) start_frames(p, 1);
    // Back-to-back frames with enable held
    start_frames(1, 2);

    // Randomly stalled sink
    rdy_mode = 1;
    start_frames(2, 1);
    start_frames(3, 1);
    start_frames(0, 1);

    // Async reset mid-frame, around pixel 5
    rdy_mode = 0;
    push_frame(1);
    pattern_sel = 2'd1;
    start = total_xfers;
    @(posedge clk);
    #1 enable = 1'b1;
    cyc = 0;
    while (total_xfers < start + HDR + 6 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    enable = 1'b0;
    chk("pre_rst_valid", 32'(dout_valid), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(dout_valid), 32'd0);
    chk("arst_eop", 32'(dout_endofpacket), 32'd0);
    chk("arst_data", 32'(dout_data), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_valid", 32'(dout_valid), 32'd0);
    push_frame(1);
    @(posedge clk);
    #1 enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
`ifdef VST_PATTERN_GEN_CTRL_PKT_EN
    chk("restart_data", 32'(dout_data), 32'hF);
`else
    chk("restart_data", 32'(dout_data), 32'h0);
`endif
    chk("restart_sop", 32'(dout_startofpacket), 32'd1);
    enable = 1'b0;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vst_pattern_gen.md
VST_PATTERN_GEN -- requirements
Module: vst_pattern_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 10: pixel and stream symbol width in bits, minimum 4.
REQ-002 Parameter IM_WIDTH, default 720: active pixels per line; SHALL be a multiple of 8 and at most 65535.
REQ-003 Parameter IM_HEIGHT, default 576: lines per frame, at most 65535.
REQ-004 Parameter IM_INTERLACED, default 4'd0: nibble sent as the interlace field of the control packet.
REQ-005 Parameter FILL_VALUE, default 10'd512: pixel value used by the solid pattern.
REQ-006 clk  input  1  stream clock; all logic SHALL be synchronous to its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 enable  input  1  frame generation permitted; sampled only in IDLE.
REQ-009 pattern_sel  input  2  0 solid, 1 horizontal ramp, 2 eight vertical bars, 3 checkerboard.
REQ-010 dout_data  output  DATA_WIDTH  stream symbol.
REQ-011 dout_valid  output  1  symbol valid.
REQ-012 dout_ready  input  1  sink accepts the symbol (ready latency 0).
REQ-013 dout_startofpacket / dout_endofpacket  output  1 each  first / last beat of a packet.
REQ-014 frame_done  output  1  one-cycle pulse on acceptance of the last pixel of a frame.

Function
REQ-015 A beat SHALL transfer only in cycles where dout_valid and dout_ready are both 1; while dout_valid=1 and dout_ready=0, dout_data and dout_valid and both packet flags SHALL hold unchanged.
REQ-016 FSM states SHALL be IDLE, CTRL_HDR, CTRL_BODY, VID_HDR and VID_DATA; IDLE drives dout_valid=0.
REQ-017 IDLE->CTRL_HDR when enable=1; pattern_sel SHALL be latched on that transition and held for the entire frame.
REQ-018 CTRL_HDR drives dout_data=0xF (zero-extended), dout_startofpacket=1 and goes to CTRL_BODY on transfer.
REQ-019 CTRL_BODY SHALL emit 9 beats, each zero-extended to DATA_WIDTH: IM_WIDTH[15:12], [11:8], [7:4], [3:0], then IM_HEIGHT in the same nibble order, then IM_INTERLACED; the 9th beat SHALL carry dout_endofpacket=1 and be followed by VID_HDR.
REQ-020 VID_HDR drives dout_data=0x0 and dout_startofpacket=1, then goes to VID_DATA.
REQ-021 VID_DATA SHALL emit IM_WIDTH*IM_HEIGHT pixels in raster order with x and y counters starting at 0. x SHALL wrap to 0 and y SHALL increment after x=IM_WIDTH-1.
REQ-022 The last pixel (x=IM_WIDTH-1, y=IM_HEIGHT-1) SHALL carry dout_endofpacket=1; on its transfer frame_done SHALL pulse for one cycle and the FSM SHALL return to IDLE.
REQ-023 A new frame SHALL start no earlier than the cycle after the return to IDLE: at least one cycle with dout_valid=0 between frames.
REQ-024 Pixel values: solid = FILL_VALUE; ramp = x modulo 2^DATA_WIDTH.
REQ-025 Bars pixel value: bar index b (0..7) increments every IM_WIDTH/8 pixels and SHALL be formed with a counter, not a divider; value = {b, (DATA_WIDTH-3) zero bits}.
REQ-026 Checker pixel value: all ones when x[4]^y[4]=1, else 0.
REQ-027 Deasserting enable mid-frame SHALL NOT truncate the frame; it SHALL be honoured only in IDLE.

Reset
REQ-028 While rst_n=0: FSM=IDLE, x=y=0, beat counter=0, dout_valid=0, dout_startofpacket=0, dout_endofpacket=0, frame_done=0, dout_data=0.
REQ-029 Reset asserted mid-packet SHALL abort the packet immediately with no endofpacket emitted. After release, the next packet SHALL start from CTRL_HDR (or VID_HDR per REQ-031).

Configuration
REQ-030 Macro VST_PATTERN_GEN_CTRL_PKT_EN defined: every frame is a control packet followed by a video packet, per REQ-017..REQ-022.
REQ-031 Macro undefined: CTRL_HDR and CTRL_BODY logic SHALL be absent; IDLE->VID_HDR directly and each frame is a video packet only.

Verification
REQ-032 Macro defined, IM_WIDTH=16, IM_HEIGHT=2, enable=1, dout_ready=1 -> beats: F,0,0,1,0,0,0,0,2,0 (eop on the 10th), then 0 (sop), then 32 pixels, with eop and frame_done on the 32nd.
REQ-033 pattern_sel=1, DATA_WIDTH=10, IM_WIDTH=16 -> pixels 0..15 on each line.
REQ-034 pattern_sel=2, IM_WIDTH=16 -> pixel pairs valued 0,128,256,...,896.
REQ-035 Random dout_ready with 50% duty -> no symbol dropped or duplicated, and outputs stable while stalled.
REQ-036 rst_n pulsed low at pixel 5 -> dout_valid=0 asynchronously; after release the next beat is 0xF with sop=1.
REQ-037 Macro undefined -> the first beat after enable is 0x0 with sop=1, and no 0xF beat ever appears.
